// File: rtl/serializador_palabra_byte.sv
// Word-to-byte serializer: takes one N-bit word on a valid/ready handshake and emits N/8 bytes, MSB first.
// A word is accepted in IDLE only; bytes hold on D while byte_ready is low.
module serializador_palabra_byte #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         word_valid,
    input  logic [N-1:0] W,
    output logic         word_ready,
    output logic [7:0]   D,
    output logic         byte_valid,
    input  logic         byte_ready,
    output logic         busy,
    output logic         done
);
    localparam int NB = N / 8;
    localparam int CW = $clog2(NB + 1);

    generate
        if ((N % 8) != 0 || N < 16) begin : g_bad_width
            $error("serializador_palabra_byte: N must be a multiple of 8 and at least 16");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  sr;
    logic [N-1:0]  sr_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          done_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    // The counter ends SEND before any shifted-in zero byte reaches the top of sr.
    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (word_valid) begin
                    sr_next    = W;
                    cnt_next   = CW'(NB);
                    state_next = SEND;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    sr_next  = {sr[N-9:0], 8'h00};
                    cnt_next = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign word_ready = (state == IDLE);
    assign busy       = (state == SEND);
    assign byte_valid = (state == SEND);
    assign D          = (state == SEND) ? sr[N-1:N-8] : 8'h00;

endmodule

// File: tb/tb_serializador_palabra_byte.sv
// Directed bench for serializador_palabra_byte (N=32 and N=16 instances).
module tb_serializador_palabra_byte;
    logic        clk;
    logic        rst;

    logic        word_valid;
    logic [31:0] w32;
    logic        word_ready;
    logic [7:0]  d32;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;

    logic        wv16;
    logic [15:0] w16;
    logic        wr16;
    logic [7:0]  d16;
    logic        bv16;
    logic        br16;
    logic        busy16;
    logic        done16;

    int nvec;
    int nerr;

    serializador_palabra_byte #(.N(32)) dut (
        .clk(clk), .rst(rst), .word_valid(word_valid), .W(w32), .word_ready(word_ready),
        .D(d32), .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .done(done)
    );

    serializador_palabra_byte #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .word_valid(wv16), .W(w16), .word_ready(wr16),
        .D(d16), .byte_valid(bv16), .byte_ready(br16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status packed as {word_ready, byte_valid, busy, done, D}.
    logic [11:0] st;
    logic [11:0] s16;
    assign st  = {word_ready, byte_valid, busy, done, d32};
    assign s16 = {wr16, bv16, busy16, done16, d16};

    localparam logic [11:0] ST_IDLE = 12'h800;
    localparam logic [11:0] ST_DONE = 12'h900;

    function automatic logic [11:0] st_send(input logic [7:0] b);
        return {4'b0110, b};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if (st !== ST_IDLE) begin
            nerr++;
            $display("FAIL reset_hold32: got %h expected %h", st, ST_IDLE);
        end
        nvec++;
        if (s16 !== ST_IDLE) begin
            nerr++;
            $display("FAIL reset_hold16: got %h expected %h", s16, ST_IDLE);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if (st !== ST_IDLE) begin
                nerr++;
                $display("FAIL idle_after_reset[%0d]: got %h expected %h", i, st, ST_IDLE);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        byte_ready = 1'b1;
        word_valid = 1'b1;
        w32 = 32'hA1B2C3D4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            word_valid = 1'b0;
            nvec++;
            if (st !== st_send(exp[i])) begin
                nerr++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, st, st_send(exp[i]));
            end
        end
        @(negedge clk);
        nvec++;
        if (st !== ST_DONE) begin
            nerr++;
            $display("FAIL basic_done: got %h expected %h", st, ST_DONE);
        end
        @(negedge clk);
        nvec++;
        if (st !== ST_IDLE) begin
            nerr++;
            $display("FAIL basic_done_clears: got %h expected %h", st, ST_IDLE);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4];
        logic       rdy [8];
        int         idx;
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        // byte_ready per cycle: low for three cycles while B2 is presented.
        rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        idx = 0;
        byte_ready = 1'b1;
        word_valid = 1'b1;
        w32 = 32'hA1B2C3D4;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            word_valid = 1'b0;
            nvec++;
            if (st !== st_send(exp[idx])) begin
                nerr++;
                $display("FAIL bp_cycle%0d: got %h expected %h", c, st, st_send(exp[idx]));
            end
            byte_ready = rdy[c];
            if (rdy[c]) idx++;
        end
        @(negedge clk);
        nvec++;
        if (st !== ST_DONE) begin
            nerr++;
            $display("FAIL bp_done: got %h expected %h", st, ST_DONE);
        end
        byte_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        logic [7:0] exp [8];
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44};
        byte_ready = 1'b1;
        word_valid = 1'b1;
        w32 = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            w32 = 32'h11223344;
            nvec++;
            if (st !== st_send(exp[i])) begin
                nerr++;
                $display("FAIL ignore_first%0d: got %h expected %h", i, st, st_send(exp[i]));
            end
        end
        @(negedge clk);
        nvec++;
        if (st !== ST_DONE) begin
            nerr++;
            $display("FAIL ignore_done1: got %h expected %h", st, ST_DONE);
        end
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            word_valid = 1'b0;
            nvec++;
            if (st !== st_send(exp[i])) begin
                nerr++;
                $display("FAIL ignore_second%0d: got %h expected %h", i, st, st_send(exp[i]));
            end
        end
        @(negedge clk);
        nvec++;
        if (st !== ST_DONE) begin
            nerr++;
            $display("FAIL ignore_done2: got %h expected %h", st, ST_DONE);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8];
        int         dones;
        int         bi;
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        dones = 0;
        bi = 0;
        byte_ready = 1'b1;
        word_valid = 1'b1;
        w32 = 32'h01020304;
        // 4 bytes, idle/done cycle, 4 bytes, done cycle.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            w32 = 32'h05060708;
            if (c == 5) word_valid = 1'b0;
            nvec++;
            if (c == 4 || c == 9) begin
                dones++;
                if (st !== ST_DONE) begin
                    nerr++;
                    $display("FAIL b2b_done_c%0d: got %h expected %h", c, st, ST_DONE);
                end
            end else begin
                if (st !== st_send(exp[bi])) begin
                    nerr++;
                    $display("FAIL b2b_byte%0d: got %h expected %h", bi, st, st_send(exp[bi]));
                end
                bi++;
            end
        end
        @(negedge clk);
        nvec++;
        if (st !== ST_IDLE || dones != 2) begin
            nerr++;
            $display("FAIL b2b_end: got %h expected %h", st, ST_IDLE);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp [4];
        exp = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        byte_ready = 1'b1;
        word_valid = 1'b1;
        w32 = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            word_valid = 1'b0;
            nvec++;
            if (st !== st_send(exp[i])) begin
                nerr++;
                $display("FAIL midrst_byte%0d: got %h expected %h", i, st, st_send(exp[i]));
            end
        end
        rst = 1'b1;
        #1;
        nvec++;
        if (st !== ST_IDLE) begin
            nerr++;
            $display("FAIL midrst_immediate: got %h expected %h", st, ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nvec++;
            if (st !== ST_IDLE) begin
                nerr++;
                $display("FAIL midrst_no_done%0d: got %h expected %h", i, st, ST_IDLE);
            end
        end
        exp = '{8'h00, 8'h00, 8'h00, 8'h01};
        word_valid = 1'b1;
        w32 = 32'h00000001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            word_valid = 1'b0;
            nvec++;
            if (st !== st_send(exp[i])) begin
                nerr++;
                $display("FAIL midrst_next%0d: got %h expected %h", i, st, st_send(exp[i]));
            end
        end
        @(negedge clk);
        nvec++;
        if (st !== ST_DONE) begin
            nerr++;
            $display("FAIL midrst_next_done: got %h expected %h", st, ST_DONE);
        end
        @(negedge clk);
    endtask

    task automatic test_n16();
        br16 = 1'b1;
        wv16 = 1'b1;
        w16 = 16'hBEEF;
        @(negedge clk);
        wv16 = 1'b0;
        w16 = 16'h1234;
        nvec++;
        if (s16 !== st_send(8'hBE)) begin
            nerr++;
            $display("FAIL n16_byte0: got %h expected %h", s16, st_send(8'hBE));
        end
        @(negedge clk);
        nvec++;
        if (s16 !== st_send(8'hEF)) begin
            nerr++;
            $display("FAIL n16_byte1: got %h expected %h", s16, st_send(8'hEF));
        end
        @(negedge clk);
        nvec++;
        if (s16 !== ST_DONE) begin
            nerr++;
            $display("FAIL n16_done: got %h expected %h", s16, ST_DONE);
        end
        // Reset with the first byte pending, then resend.
        wv16 = 1'b1;
        w16 = 16'hBEEF;
        @(negedge clk);
        wv16 = 1'b0;
        nvec++;
        if (s16 !== st_send(8'hBE)) begin
            nerr++;
            $display("FAIL n16_rst_pre: got %h expected %h", s16, st_send(8'hBE));
        end
        rst = 1'b1;
        #1;
        nvec++;
        if (s16 !== ST_IDLE) begin
            nerr++;
            $display("FAIL n16_rst_immediate: got %h expected %h", s16, ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (s16 !== ST_IDLE) begin
            nerr++;
            $display("FAIL n16_rst_no_done: got %h expected %h", s16, ST_IDLE);
        end
        wv16 = 1'b1;
        @(negedge clk);
        wv16 = 1'b0;
        nvec++;
        if (s16 !== st_send(8'hBE)) begin
            nerr++;
            $display("FAIL n16_resend0: got %h expected %h", s16, st_send(8'hBE));
        end
        @(negedge clk);
        nvec++;
        if (s16 !== st_send(8'hEF)) begin
            nerr++;
            $display("FAIL n16_resend1: got %h expected %h", s16, st_send(8'hEF));
        end
        @(negedge clk);
        nvec++;
        if (s16 !== ST_DONE) begin
            nerr++;
            $display("FAIL n16_resend_done: got %h expected %h", s16, ST_DONE);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        word_valid = 1'b0;
        w32 = '0;
        byte_ready = 1'b0;
        wv16 = 1'b0;
        w16 = '0;
        br16 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignore_busy();
        test_back_to_back();
        test_mid_reset();
        test_n16();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/serializador_palabra_byte.md
Name: serializador_palabra_byte

Overview:
Word-to-byte serializer, the transmit-side counterpart of the byte-assembling left-shift register. It accepts one N-bit word through a valid/ready handshake and emits it as N/8 bytes, most-significant byte first, through a byte valid/ready handshake. Byte order is chosen so that a downstream left-shift byte assembler reconstructs the original word. It sits between the parallel datapath and the byte-wide link toward the UART/host side.

Parameters:
N, 32, word width in bits. Must be a multiple of 8 and at least 16.
NB, N/8, number of bytes per word. Derived only, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
word_valid  input  1  W holds a word to send.
W  input  N  word to serialize.
word_ready  output  1  block can accept a word this cycle.
D  output  8  current byte.
byte_valid  output  1  D is valid.
byte_ready  input  1  sink accepts D this cycle.
busy  output  1  a word is being serialized.
done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; shift register and byte counter = 0.
  - D=0, byte_valid=0, busy=0, done=0, word_ready=1.
- Internal state:
  - Shift register SR[N-1:0].
  - Byte counter CNT, width ceil(log2(NB+1)).
  - FSM with states IDLE and SEND.
- Output decode:
  - word_ready = (state==IDLE).
  - busy = (state==SEND).
  - byte_valid = (state==SEND).
  - D = SR[N-1:N-8] in SEND, 0 in IDLE.
  - done is registered.
- IDLE:
  - On rising edge with word_valid=1: SR<=W, CNT<=NB, next state SEND.
  - Otherwise hold.
  - byte_ready is ignored in IDLE.
- SEND:
  - On rising edge with byte_ready=1:
    - SR <= {SR[N-9:0], 8'h00}, CNT <= CNT-1.
    - If CNT==1: next state IDLE and done<=1 for exactly one cycle.
  - With byte_ready=0: SR, CNT and D hold. D must be stable while byte_valid=1 and byte_ready=0.
  - word_valid and W are ignored in SEND. No word is accepted until IDLE is re-entered.
- Latency and throughput:
  - Word accepted at edge k: first byte valid in the cycle after edge k.
  - With byte_ready held at 1, byte i (i=0..NB-1) is accepted at edge k+1+i.
  - done is high in the cycle after edge k+NB.
  - word_ready returns to 1 in that same cycle.
  - Minimum NB+1 cycles per word.
- done is a pulse only: cleared on the next edge regardless of word_valid. A new word can be accepted on the same edge that clears done.
- Zero padding: shifted-in zeros are never presented as valid bytes, because the counter ends SEND first.
- Reset mid-operation: the word in flight is discarded with no done pulse. The block returns to IDLE with the reset values above.
- W changes after acceptance do not affect bytes already latched in SR.

Test Plan:
- Reset, then idle: after rst deasserts, word_ready=1, byte_valid=0, D=0, busy=0, done=0 for 5 cycles with word_valid=0.
- Basic word, byte_ready held at 1, N=32:
  - Stimulus: W=32'hA1B2C3D4 with word_valid for 1 cycle.
  - Required: bytes A1, B2, C3, D4 on 4 consecutive cycles starting the cycle after acceptance.
  - done pulses 1 cycle after D4 is accepted; word_ready=0 throughout SEND.
- Backpressure:
  - Stimulus: same word, byte_ready low for 3 cycles on the second byte.
  - Required: D=B2 held stable with byte_valid=1 for all 3 stall cycles; order and count unchanged; done after D4 only.
- Ignored input while busy:
  - Stimulus: word_valid=1 with W=32'h11223344 during SEND of 32'hDEADBEEF.
  - Required: output is exactly DE, AD, BE, EF. Then 11, 22, 33, 44 only if word_valid is still high once IDLE is re-entered.
- Back-to-back words:
  - Stimulus: word_valid held high, W=32'h01020304 then 32'h05060708, byte_ready=1.
  - Required: 8 bytes 01..08 in order, one IDLE cycle between words, two done pulses.
- Reset mid-word:
  - Stimulus: assert rst after byte 2 of 32'hCAFEF00D.
  - Required: immediate byte_valid=0 and D=0; no done pulse; next word 32'h00000001 emits 00, 00, 00, 01.
  - Also checked with N=16: 16'hBEEF emits BE, EF.
